// File: rtl/dmi_reg_bridge.sv
// DMI request/response to simple register bus bridge.
// One access at a time, with a bus timeout and a drain of late completions.
module dmi_reg_bridge #(
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned CntWidth      = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [40:0] dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output logic [33:0] dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [6:0]  bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    // state | meaning
    // IDLE  | waiting for a DMI request (blocked while draining)
    // REQ   | bus_req asserted, waiting for gnt
    // WAIT  | granted, waiting for rvalid
    // RESP  | response valid, waiting for dmi_resp_ready
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] RSP_OK   = 2'd0;
    localparam logic [1:0] RSP_FAIL = 2'd2;

    localparam bit TmoEn = (TimeoutCycles != 0);
    localparam logic [CntWidth-1:0] TmoLast =
        TmoEn ? CntWidth'(TimeoutCycles - 1) : '0;

    state_e              state_q, state_d;
    logic                drain_q, drain_d;
    logic                we_q, we_d;
    logic [6:0]          addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [33:0]         resp_q, resp_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                tmo_hit;
    logic [1:0]          req_op;

    assign req_op  = dmi_req_i[33:32];
    assign tmo_hit = TmoEn && (cnt_q == TmoLast);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        cnt_d   = cnt_q;

        // A late completion of a timed-out access is swallowed here.
        if (drain_q && bus_rvalid_i) begin
            drain_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (dmi_req_valid_i && !drain_q) begin
                    if (req_op == OP_READ || req_op == OP_WRITE) begin
                        addr_d  = dmi_req_i[40:34];
                        we_d    = (req_op == OP_WRITE);
                        wdata_d = dmi_req_i[31:0];
                        cnt_d   = '0;
                        state_d = REQ;
                    end else if (req_op == OP_NOP) begin
                        resp_d  = {32'h0, RSP_OK};
                        state_d = RESP;
                    end else begin
                        resp_d  = {32'h0, RSP_FAIL};
                        state_d = RESP;
                    end
                end
            end
            REQ: begin
                if (TmoEn) begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
                if (bus_gnt_i) begin
                    state_d = WAIT;
                end else if (tmo_hit) begin
                    resp_d  = {32'h0, RSP_FAIL};
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (TmoEn) begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
                if (bus_rvalid_i) begin
                    resp_d  = {(we_q ? 32'h0 : bus_rdata_i),
                               (bus_err_i ? RSP_FAIL : RSP_OK)};
                    state_d = RESP;
                end else if (tmo_hit) begin
                    resp_d  = {32'h0, RSP_FAIL};
                    drain_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (dmi_resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dmi_req_ready_o  = (state_q == IDLE) && !drain_q;
    assign dmi_resp_valid_o = (state_q == RESP);
    assign dmi_resp_o       = resp_q;
    assign bus_req_o        = (state_q == REQ);
    assign bus_we_o         = we_q;
    assign bus_addr_o       = addr_q;
    assign bus_wdata_o      = wdata_q;

endmodule

// File: tb/tb_dmi_reg_bridge.sv
// Scoreboard bench for dmi_reg_bridge with an 8-cycle timeout.
module tb_dmi_reg_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [40:0] dmi_req_i = '0;
    logic        dmi_req_valid_i = 1'b0;
    logic        dmi_req_ready_o;
    logic [33:0] dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i = 1'b0;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [6:0]  bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_err_i = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    dmi_reg_bridge #(.TimeoutCycles(8), .CntWidth(4)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .dmi_req_i        (dmi_req_i),
        .dmi_req_valid_i  (dmi_req_valid_i),
        .dmi_req_ready_o  (dmi_req_ready_o),
        .dmi_resp_o       (dmi_resp_o),
        .dmi_resp_valid_o (dmi_resp_valid_o),
        .dmi_resp_ready_i (dmi_resp_ready_i),
        .bus_req_o        (bus_req_o),
        .bus_we_o         (bus_we_o),
        .bus_addr_o       (bus_addr_o),
        .bus_wdata_o      (bus_wdata_o),
        .bus_gnt_i        (bus_gnt_i),
        .bus_rvalid_i     (bus_rvalid_i),
        .bus_rdata_i      (bus_rdata_i),
        .bus_err_i        (bus_err_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request, push its expected response, return one cycle after accept.
    task automatic send(input logic [6:0] a, input logic [1:0] op,
                        input logic [31:0] d, input logic [33:0] exp);
        for (int i = 0; i < 20; i++) begin
            if (dmi_req_ready_o) break;
            tick();
        end
        chk("req_ready", dmi_req_ready_o, 1);
        dmi_req_i       = {a, op, d};
        dmi_req_valid_i = 1'b1;
        exp_q.push_back(exp);
        tick();
        dmi_req_valid_i = 1'b0;
        dmi_req_i       = '0;
    endtask

    task automatic finish_resp(input string tag);
        logic found;
        logic [33:0] e;
        found = 1'b0;
        dmi_resp_ready_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (dmi_resp_valid_o) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) begin
            chk({tag, "_timeout"}, 0, 1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, dmi_resp_o, e);
        end
        tick();
        dmi_resp_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_resp_valid", dmi_resp_valid_o, 0);
        chk("rst_resp", dmi_resp_o, 0);
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_bus_wdata", bus_wdata_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // 1: READ with immediate gnt, rvalid one cycle later
        send(7'h11, 2'd1, 32'h0, {32'hDEADBEEF, 2'd0});
        chk("t1_req", bus_req_o, 1);
        chk("t1_we", bus_we_o, 0);
        chk("t1_addr", bus_addr_o, 7'h11);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        chk("t1_req_drop", bus_req_o, 0);
        chk("t1_valid_early", dmi_resp_valid_o, 0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hDEADBEEF;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        chk("t1_valid_t3", dmi_resp_valid_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_hold_valid", dmi_resp_valid_o, 1);
            chk("t1_hold_data", dmi_resp_o, {32'hDEADBEEF, 2'd0});
        end
        finish_resp("t1_resp");

        // 2: WRITE, gnt after 4 cycles, slave error
        send(7'h10, 2'd2, 32'h80000001, {32'h0, 2'd2});
        for (int i = 0; i < 4; i++) begin
            chk("t2_req", bus_req_o, 1);
            chk("t2_we", bus_we_o, 1);
            chk("t2_wdata", bus_wdata_o, 32'h80000001);
            tick();
        end
        bus_gnt_i = 1'b1;
        chk("t2_wdata_gnt", bus_wdata_o, 32'h80000001);
        tick();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_err_i    = 1'b1;
        bus_rdata_i  = 32'h0000FFFF;
        tick();
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
        bus_rdata_i  = '0;
        finish_resp("t2_resp");

        // 3: NOP and reserved op, no bus access
        send(7'h05, 2'd0, 32'h12345678, {32'h0, 2'd0});
        chk("t3_nop_valid", dmi_resp_valid_o, 1);
        chk("t3_nop_noreq", bus_req_o, 0);
        finish_resp("t3_nop_resp");
        send(7'h06, 2'd3, 32'h87654321, {32'h0, 2'd2});
        chk("t3_rsv_valid", dmi_resp_valid_o, 1);
        chk("t3_rsv_noreq", bus_req_o, 0);
        finish_resp("t3_rsv_resp");

        // 4: WAIT timeout, then drain of a late rvalid
        send(7'h22, 2'd1, 32'h0, {32'h0, 2'd2});
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("t4_no_valid", dmi_resp_valid_o, 0);
            tick();
        end
        chk("t4_tmo_valid", dmi_resp_valid_o, 1);
        finish_resp("t4_resp");
        for (int i = 0; i < 3; i++) begin
            chk("t4_drain_ready", dmi_req_ready_o, 0);
            tick();
        end
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1234;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        chk("t4_ready_back", dmi_req_ready_o, 1);
        for (int i = 0; i < 2; i++) begin
            chk("t4_no_resp", dmi_resp_valid_o, 0);
            tick();
        end
        chk("t4_sb_empty", exp_q.size(), 0);

        // 5: REQ timeout, gnt never comes
        send(7'h33, 2'd1, 32'h0, {32'h0, 2'd2});
        for (int i = 0; i < 8; i++) begin
            chk("t5_req_held", bus_req_o, 1);
            tick();
        end
        chk("t5_req_drop", bus_req_o, 0);
        chk("t5_tmo_valid", dmi_resp_valid_o, 1);
        finish_resp("t5_resp");
        chk("t5_ready_now", dmi_req_ready_o, 1);

        // 6: reset in WAIT
        send(7'h44, 2'd2, 32'hA5A5A5A5, {32'h0, 2'd0});
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_req", bus_req_o, 0);
        chk("t6_rst_we", bus_we_o, 0);
        chk("t6_rst_addr", bus_addr_o, 0);
        chk("t6_rst_wdata", bus_wdata_o, 0);
        chk("t6_rst_valid", dmi_resp_valid_o, 0);
        chk("t6_rst_resp", dmi_resp_o, 0);
        exp_q.delete();
        tick();
        rst_ni = 1'b1;
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hBAD0BAD0;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        chk("t6_ignored_valid", dmi_resp_valid_o, 0);
        chk("t6_ignored_ready", dmi_req_ready_o, 1);
        send(7'h7F, 2'd1, 32'h0, {32'hCAFEF00D, 2'd0});
        chk("t6_addr", bus_addr_o, 7'h7F);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hCAFEF00D;
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        finish_resp("t6_resp");
        chk("end_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
